// File: rtl/alu_muldiv_control.sv
// alu_muldiv_control
//   ALU control decoder for the MIPS datapath plus an iterative
//   multiply/divide engine with HI/LO registers.
//
//   Ports:
//     clk, reset     - rising-edge clock, synchronous active-high reset
//     start          - decode-stage instruction valid
//     ALUOp, Funct   - main-decoder ALUOp and instruction funct field
//     SrcA, SrcB     - rs / rt operands (dividend|multiplicand, divisor|multiplier)
//     ALUControl     - single-cycle ALU operation select (combinational)
//     stall          - freeze PC / pipeline registers
//     busy           - engine iterating (MUL or DIV state)
//     done           - one-cycle pulse, HI/LO just updated
//     hi, lo         - HI / LO registers
//     hilo_data      - MFHI -> hi, MFLO -> lo, otherwise zero
module alu_muldiv_control #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [2:0]       ALUControl,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hilo_data
);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   acc_r;     // partial product high half / partial remainder
    logic [WIDTH-1:0]   sh_r;      // multiplier (shifts out) / dividend->quotient
    logic [WIDTH-1:0]   opnd_r;    // multiplicand / divisor magnitude
    logic               neg_q_r;   // negate product or quotient
    logic               neg_r_r;   // negate remainder (dividend negative)
    logic               zero_r;    // divisor was zero
    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               busy_r, done_r;

    logic               is_muldiv_s, accept_s, last_s, signed_op_s;
    logic [WIDTH-1:0]   abs_a_s, abs_b_s;
    logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [WIDTH-1:0]   mul_acc_s, mul_sh_s, div_acc_s, div_sh_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s, rem_fix_s;

    // Single-cycle ALU operation decode
    always_comb begin
        ALUControl = 3'b010;
        case (ALUOp)
            2'b00: ALUControl = 3'b010;
            2'b01: ALUControl = 3'b100;
            2'b10: begin
                case (Funct)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b100;
                    6'b101010: ALUControl = 3'b110;
                    6'b011100: ALUControl = 3'b101;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    assign is_muldiv_s = (ALUOp == 2'b10) &&
                         ((Funct == F_MULT) || (Funct == F_MULTU) ||
                          (Funct == F_DIV)  || (Funct == F_DIVU));
    assign accept_s    = start && is_muldiv_s && ((state_r == IDLE) || (state_r == DONE));
    assign last_s      = (cnt_r == LAST_CNT);
    // Funct bit 0 clear selects the signed variant, bit 1 set selects divide.
    assign signed_op_s = ~Funct[0];
    assign abs_a_s     = (signed_op_s && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    assign abs_b_s     = (signed_op_s && SrcB[WIDTH-1]) ? -SrcB : SrcB;

    assign stall     = busy_r || accept_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign hi        = hi_r;
    assign lo        = lo_r;
    assign hilo_data = (ALUOp == 2'b10 && Funct == F_MFHI) ? hi_r :
                       (ALUOp == 2'b10 && Funct == F_MFLO) ? lo_r : {WIDTH{1'b0}};

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_nxt_s = Funct[1] ? DIV : MUL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MUL, DIV: begin
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered busy/done decodes
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == MUL) || (state_nxt_s == DIV);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // One shift-add multiply step: add multiplicand if multiplier LSB set,
    // then shift the {acc, multiplier} pair right by one.
    assign mul_sum_s = {1'b0, acc_r} + (sh_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign mul_acc_s = mul_sum_s[WIDTH:1];
    assign mul_sh_s  = {mul_sum_s[0], sh_r[WIDTH-1:1]};

    // One restoring divide step. The partial remainder never exceeds
    // 2*divisor, so WIDTH+1 bits hold the trial difference; a zero divisor
    // simply produces all-ones quotient bits and leaves the dividend as remainder.
    assign div_shift_s = {acc_r, sh_r[WIDTH-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};

    // Restoring divide select
    always_comb begin
        div_acc_s = div_shift_s[WIDTH-1:0];
        div_sh_s  = {sh_r[WIDTH-2:0], 1'b0};
        if (!div_diff_s[WIDTH]) begin
            div_acc_s = div_diff_s[WIDTH-1:0];
            div_sh_s  = {sh_r[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_s = div_shift_s[WIDTH-1:0];
            div_sh_s  = {sh_r[WIDTH-2:0], 1'b0};
        end
    end

    assign prod_s     = {mul_acc_s, mul_sh_s};
    assign prod_fix_s = neg_q_r ? -prod_s : prod_s;
    assign quo_fix_s  = zero_r ? {WIDTH{1'b1}} : (neg_q_r ? -div_sh_s : div_sh_s);
    assign rem_fix_s  = neg_r_r ? -div_acc_s : div_acc_s;

    // Engine datapath, counter and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            sh_r    <= {WIDTH{1'b0}};
            opnd_r  <= {WIDTH{1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            zero_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r   <= {CNT_W{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            sh_r    <= Funct[1] ? abs_a_s : abs_b_s;
            opnd_r  <= Funct[1] ? abs_b_s : abs_a_s;
            neg_q_r <= signed_op_s && (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            neg_r_r <= signed_op_s && SrcA[WIDTH-1];
            zero_r  <= (SrcB == {WIDTH{1'b0}});
        end else if (state_r == MUL || state_r == DIV) begin
            cnt_r <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_ONE;
            acc_r <= (state_r == MUL) ? mul_acc_s : div_acc_s;
            sh_r  <= (state_r == MUL) ? mul_sh_s  : div_sh_s;
            if (last_s) begin
                hi_r <= (state_r == MUL) ? prod_fix_s[2*WIDTH-1:WIDTH] : rem_fix_s;
                lo_r <= (state_r == MUL) ? prod_fix_s[WIDTH-1:0]       : quo_fix_s;
            end
        end
    end

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Directed self-checking bench for alu_muldiv_control (WIDTH = 32).
module tb_alu_muldiv_control;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   ALUOp;
    logic [5:0]   Funct;
    logic [W-1:0] SrcA, SrcB;
    logic [2:0]   ALUControl;
    logic         stall, busy, done;
    logic [W-1:0] hi, lo, hilo_data;

    int n_assert = 0;
    int n_fail   = 0;

    alu_muldiv_control #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .ALUOp(ALUOp), .Funct(Funct),
        .SrcA(SrcA), .SrcB(SrcB), .ALUControl(ALUControl), .stall(stall),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .hilo_data(hilo_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one mul/div, then wait (bounded) for done; lat counts edges incl. accept.
    task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat);
        ALUOp = 2'b10; Funct = f; SrcA = a; SrcB = b; start = 1'b1;
        #1;
        chk("accept_stall", stall, 1);
        step();
        start = 1'b0; Funct = 6'b000000;
        lat = 1;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
    endtask

    logic [1:0] dec_op  [10] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] dec_fn  [10] = '{6'b011000, 6'b011010, 6'b011001, 6'b100000, 6'b100010,
                                 6'b101010, 6'b011100, 6'b100100, 6'b100101, 6'b111111};
    logic [2:0] dec_exp [10] = '{3'b010, 3'b100, 3'b010, 3'b010, 3'b100,
                                 3'b110, 3'b101, 3'b000, 3'b001, 3'b010};

    initial begin
        int lat;
        reset = 1'b1; start = 1'b0; ALUOp = 2'b00; Funct = 6'b000000;
        SrcA = '0; SrcB = '0;
        step(); step();
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_stall", stall, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);

        // Decode sweep with start held high: none is a mul/div so no stall
        for (int i = 0; i < 10; i++) begin
            ALUOp = dec_op[i]; Funct = dec_fn[i]; start = 1'b1;
            #1;
            chk($sformatf("dec_%0d", i), ALUControl, dec_exp[i]);
            chk($sformatf("dec_stall_%0d", i), stall, 0);
        end
        start = 1'b0;
        step();

        // MULTU 0xFFFFFFFF * 2: stall for 33 cycles, done in the 34th
        ALUOp = 2'b10; Funct = 6'b011001; SrcA = 32'hFFFF_FFFF; SrcB = 32'h0000_0002; start = 1'b1;
        #1;
        chk("multu_stall_c1", stall, 1);
        step();
        start = 1'b0; Funct = 6'b000000;
        for (int c = 2; c <= 33; c++) begin
            chk($sformatf("multu_stall_c%0d", c), stall, 1);
            chk($sformatf("multu_nodone_c%0d", c), done, 0);
            step();
        end
        chk("multu_done", done, 1);
        chk("multu_busy", busy, 0);
        chk("multu_stall_done", stall, 0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // MULT -3 * 7 (issued from DONE)
        do_op(6'b011000, 32'hFFFF_FFFD, 32'h0000_0007, lat);
        chk("mult_lat", lat, 33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        // DIV -7 / 2
        do_op(6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, lat);
        chk("div_lat", lat, 33);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 100 / 0
        do_op(6'b011011, 32'h0000_0064, 32'h0000_0000, lat);
        chk("divz_lat", lat, 33);
        chk("divz_lo", lo, 32'hFFFF_FFFF);
        chk("divz_hi", hi, 32'h0000_0064);

        // DIV MIN / -1
        do_op(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("divmin_lo", lo, 32'h8000_0000);
        chk("divmin_hi", hi, 32'h0000_0000);

        // MULTU 5*6, then MFLO waiting in decode during busy
        ALUOp = 2'b10; Funct = 6'b011001; SrcA = 32'd5; SrcB = 32'd6; start = 1'b1;
        step();
        Funct = 6'b010010;
        lat = 1;
        while (!done && lat < 60) begin
            chk("mflo_stall", stall, 1);
            step();
            lat++;
        end
        chk("mflo_lat", lat, 33);
        chk("mflo_stall_done", stall, 0);
        chk("mflo_data", hilo_data, 32'h0000_001E);
        Funct = 6'b010000;
        #1;
        chk("mfhi_data", hilo_data, 32'h0000_0000);

        // Back-to-back MULTU accepted in the DONE cycle
        Funct = 6'b011001; SrcA = 32'd3; SrcB = 32'd4; start = 1'b1;
        #1;
        chk("b2b_stall", stall, 1);
        step();
        start = 1'b0; Funct = 6'b000000;
        chk("b2b_busy", busy, 1);
        chk("b2b_done_low", done, 0);
        lat = 1;
        while (!done && lat < 60) begin
            step();
            lat++;
        end
        chk("b2b_lat", lat, 33);
        chk("b2b_lo", lo, 32'h0000_000C);

        // Reset at iteration 10 of DIVU
        ALUOp = 2'b10; Funct = 6'b011011; SrcA = 32'd1000; SrcB = 32'd7; start = 1'b1;
        step();
        start = 1'b0; Funct = 6'b000000;
        for (int i = 0; i < 10; i++) step();
        chk("mid_busy_pre", busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_stall", stall, 0);
        chk("mid_done", done, 0);
        chk("mid_hi", hi, 0);
        chk("mid_lo", lo, 0);
        for (int i = 0; i < 30; i++) begin
            step();
            chk("mid_no_done", done, 0);
        end
        chk("mid_lo_end", lo, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
